pio_in_edge: RTL

Parametrised Avalon-MM input PIO slave. Successor to the fixed-width, read-only switch port. Samples a `WIDTH`-bit asynchronous input bus through a two-flop synchroniser, latches per-bit edges into a sticky capture register, and raises a maskable level interrupt. It sits between board switches or buttons and the Nios II data master, on the system interconnect.

---
 rtl/pio_in_pkg.sv | 13 +
 rtl/pio_in_edge_if.sv | 10 +
 rtl/pio_in_cond.sv | 47 ++++
 rtl/pio_in_edge.sv | 57 +++++
 4 files changed

// File: rtl/pio_in_pkg.sv
// pio_in_pkg: register offsets, edge-mode codes and shared helpers for pio_in_edge
package pio_in_pkg;
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY = 2;
  localparam int DEB_W = 16;
  function automatic logic [31:0] pio_edge(input int mode, input logic [31:0] c, input logic [31:0] p);
    return mode == EDGE_RISE ? c & ~p : mode == EDGE_FALL ? ~c & p : c ^ p;
  endfunction
endpackage

// File: rtl/pio_in_edge_if.sv
// pio_in_edge_if: Avalon-MM slave bus bundle for the input PIO
interface pio_in_edge_if;
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_in_cond.sv
// pio_in_cond: two-flop input synchroniser with per-bit debounce when PIO_IN_DEBOUNCE_EN is defined
module pio_in_cond
  import pio_in_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] cond_o
);
  logic [WIDTH-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end
`ifdef PIO_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic stable_q, stable_d, done;
    // a bit only moves after sync2 has disagreed with it for DEBOUNCE_CYCLES edges
    always_comb begin
      done = cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1);
      stable_d = (sync2_q[i] != stable_q && done) ? sync2_q[i] : stable_q;
      cnt_d = (sync2_q[i] != stable_q && !done) ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        stable_q <= stable_d;
      end
    end
    assign cond_o[i] = stable_q;
  end
`else
  assign cond_o = sync2_q;
`endif
endmodule

// File: rtl/pio_in_edge.sv
// pio_in_edge: Avalon-MM input PIO with sticky edge capture and masked irq; PIO_IN_DEBOUNCE_EN adds debounce
module pio_in_edge
  import pio_in_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  pio_in_edge_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  output logic irq
);
  logic [WIDTH-1:0] cond, prev_q, mask_q, mask_d, cap_q, cap_d, ev, clr;
  logic [1:0] warm_q, warm_d;
  logic [31:0] rdata_q, rdata_d;
  logic irq_q, irq_d, wr;
  pio_in_cond #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
    .clk(clk),
    .reset_n(reset_n),
    .in_i(in_port),
    .cond_o(cond)
  );
  // warm-up keeps inputs held high through reset from looking like edges
  always_comb begin
    wr = bus.chipselect & ~bus.write_n;
    warm_d = warm_q == 2'd3 ? warm_q : warm_q + 2'd1;
    ev = WIDTH'(pio_edge(EDGE_MODE, 32'(cond), 32'(prev_q)));
    clr = (wr && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    cap_d = (cap_q & ~clr) | (ev & {WIDTH{warm_q == 2'd3}});
    mask_d = (wr && bus.address == PIO_ADDR_IRQMASK) ? bus.writedata[WIDTH-1:0] : mask_q;
    irq_d = |(cap_q & mask_q);
    rdata_d = bus.address == PIO_ADDR_DATA ? 32'(cond) :
              bus.address == PIO_ADDR_IRQMASK ? 32'(mask_q) :
              bus.address == PIO_ADDR_EDGECAP ? 32'(cap_q) : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      warm_q <= '0;
      mask_q <= '0;
      cap_q <= '0;
      irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      prev_q <= cond;
      warm_q <= warm_d;
      mask_q <= mask_d;
      cap_q <= cap_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.readdata = rdata_q;
  assign irq = irq_q;
endmodule
